// File: rtl/prga_decrypt_fsm.sv
// prga_decrypt_fsm: RC4 keystream generator and decryptor.
// Runs after the KSA has filled s_memory. For each ciphertext byte it does one
// PRGA step: swap S[i] and S[j], then XOR S[S[i]+S[j]] with message_rom[k]
// and write the result to decrypted_ram[k]. Each byte takes 10 cycles.
// Optional build macro PLAINTEXT_CHECK_EN: abort early and clear key_valid
// when a decrypted byte is neither 'a'..'z' nor a space.
module prga_decrypt_fsm #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  output logic              finish,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] m_address,
  input  logic [7:0]        m_q,
  output logic [MSG_AW-1:0] d_address,
  output logic [7:0]        d_data,
  output logic              d_wren,
  output logic              key_valid
);

  typedef enum logic [3:0] {
    IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, RD_F, WT_F, WR_D, NEXT, DONE
  } state_t;

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  state_t            r_state, w_next;
  logic [7:0]        r_i, r_j, r_si, r_sj, r_f, r_enc;
  logic [MSG_AW-1:0] r_k;
  logic [7:0]        w_dec;
  logic              w_k_last;

  assign w_dec    = r_f ^ r_enc;
  assign w_k_last = (r_k == K_LAST);

`ifdef PLAINTEXT_CHECK_EN
  logic r_key_valid;
  logic w_bad;
  // Only lowercase letters and space count as plausible plaintext.
  assign w_bad     = !(((w_dec >= 8'h61) && (w_dec <= 8'h7A)) || (w_dec == 8'h20));
  assign key_valid = r_key_valid;
`else
  assign key_valid = 1'b1;
`endif

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state sequencing and Moore-decoded memory port outputs.
  always_comb begin
    w_next    = r_state;
    finish    = 1'b0;
    s_address = 8'h00;
    s_data    = 8'h00;
    s_wren    = 1'b0;
    m_address = '0;
    d_address = '0;
    d_data    = 8'h00;
    d_wren    = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = RD_I;
      RD_I: begin
        s_address = r_i + 8'd1;
        w_next    = WT_I;
      end
      WT_I: w_next = RD_J;
      RD_J: begin
        s_address = r_j;
        w_next    = WT_J;
      end
      WT_J: w_next = WR_I;
      WR_I: begin
        s_address = r_i;
        s_data    = r_sj;
        s_wren    = 1'b1;
        w_next    = WR_J;
      end
      WR_J: begin
        s_address = r_j;
        s_data    = r_si;
        s_wren    = 1'b1;
        w_next    = RD_F;
      end
      RD_F: begin
        // si/sj are the pre-swap values, so their sum equals S[i]+S[j] after the swap.
        s_address = r_si + r_sj;
        m_address = r_k;
        w_next    = WT_F;
      end
      WT_F: w_next = WR_D;
      WR_D: begin
        d_address = r_k;
        d_data    = w_dec;
        d_wren    = 1'b1;
`ifdef PLAINTEXT_CHECK_EN
        w_next    = w_bad ? DONE : NEXT;
`else
        w_next    = NEXT;
`endif
      end
      NEXT: w_next = w_k_last ? DONE : RD_I;
      DONE: begin
        finish = 1'b1;
        if (start) w_next = RD_I;
      end
      default: w_next = IDLE;
    endcase
  end

  // Index and byte registers, updated by the state that owns each one.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_i   <= 8'h00;
      r_j   <= 8'h00;
      r_k   <= '0;
      r_si  <= 8'h00;
      r_sj  <= 8'h00;
      r_f   <= 8'h00;
      r_enc <= 8'h00;
`ifdef PLAINTEXT_CHECK_EN
      r_key_valid <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_i <= 8'h00;
          r_j <= 8'h00;
          r_k <= '0;
`ifdef PLAINTEXT_CHECK_EN
          r_key_valid <= 1'b1;
`endif
        end
        RD_I: r_i <= r_i + 8'd1;
        WT_I: begin
          r_si <= s_q;
          r_j  <= r_j + s_q;
        end
        WT_J: r_sj <= s_q;
        WT_F: begin
          r_f   <= s_q;
          r_enc <= m_q;
        end
`ifdef PLAINTEXT_CHECK_EN
        WR_D: if (w_bad) r_key_valid <= 1'b0;
`endif
        NEXT: if (!w_k_last) r_k <= r_k + MSG_AW'(1);
        default: ;
      endcase
    end
  end

endmodule
